anubis_seq_ctrl: RTL

ANUBIS_SEQ_CTRL -- requirements
Module: anubis_seq_ctrl

---
 rtl/anubis_seq_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/anubis_seq_ctrl.sv
//==============================================================================
// Module      : anubis_seq_ctrl
// Description : Sequencing controller wrapping an Anubis_2 core: drives the
//               key-setup / load / run order trace for one plaintext block
//               and hands the ciphertext downstream with a valid/ready pair.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module anubis_seq_ctrl #(
    parameter int KEY_CYCLES = 3,
    parameter int RUN_CYCLES = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [1:0]   core_order,
    output logic [127:0] core_data_in,
    input  logic [127:0] core_data_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [5:0] C_KEY_LAST = 6'(KEY_CYCLES - 1);
    localparam logic [5:0] C_RUN_LAST = 6'(RUN_CYCLES - 1);

    localparam logic [1:0] C_ORDER_KEY  = 2'b00;
    localparam logic [1:0] C_ORDER_LOAD = 2'b01;
    localparam logic [1:0] C_ORDER_RUN  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_KEY  = 3'd1,
        S_LOAD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [5:0] r_cnt;
    logic [5:0] w_cnt_next;
    logic       w_accept;
    logic       w_capture;
    logic [1:0] w_order_next;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    w_accept     = 1'b1;
                    w_cnt_next   = C_KEY_LAST;
                    w_state_next = S_KEY;
                end
            end
            S_KEY: begin
                if (r_cnt == 6'd0) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_cnt_next = r_cnt - 6'd1;
                end
            end
            S_LOAD: begin
                w_cnt_next   = C_RUN_LAST;
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (r_cnt == 6'd0) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DONE;
                end else begin
                    w_cnt_next = r_cnt - 6'd1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        case (w_state_next)
            S_LOAD:  w_order_next = C_ORDER_LOAD;
            S_RUN:   w_order_next = C_ORDER_RUN;
            default: w_order_next = C_ORDER_KEY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 6'd0;
            in_ready     <= 1'b0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            core_order   <= C_ORDER_KEY;
            core_data_in <= 128'd0;
            out_data     <= 128'd0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            in_ready   <= (w_state_next == S_IDLE);
            busy       <= (w_state_next != S_IDLE);
            out_valid  <= (w_state_next == S_DONE);
            core_order <= w_order_next;
            if (w_accept) begin
                core_data_in <= in_data;
            end
            if (w_capture) begin
                out_data <= core_data_out;
            end
        end
    end

endmodule

`default_nettype wire
